// File: rtl/output_fifo.sv
// First-word-fall-through FIFO behind the stalling pipeline. It supplies the
// pipeline's back-pressure and exports occupancy, almost-full and a high-watermark.
module output_fifo #(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16,
    parameter int AF_LEVEL  = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    input  logic [DATA_SIZE-1:0]       data_in,
    output logic                       in_ready,
    output logic                       rd_valid,
    output logic [DATA_SIZE-1:0]       rd_data,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     max_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_next;
    logic                 wr_en;
    logic                 rd_en;

    // Handshakes: a word moves on a rising edge only when valid and ready are both
    // high. in_ready and rd_valid depend on registered state only, so neither side
    // can loop combinationally through this block.
    assign in_ready    = (count != FULL_CNT);
    assign rd_valid    = (count != '0);
    assign almost_full = (count >= AF_CNT);
    assign rd_data     = mem[rd_ptr];

    assign wr_en = valid_in && in_ready;
    assign rd_en = rd_valid && rd_ready;

    always_comb begin
        count_next = count;
        case ({wr_en, rd_en})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            max_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            if (count_next > max_level) max_level <= count_next;
        end
    end

    // Storage has no reset; a write arriving during reset is suppressed so the
    // dropped word cannot be confused with live data.
    always_ff @(posedge clk) begin
        if (reset && wr_en) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_output_fifo.sv
// Self-checking bench for output_fifo: a queue scoreboard plus an occupancy
// model, one task per scenario.
module tb_output_fifo;

    logic       clk;
    logic       reset;
    logic       valid_in;
    logic [7:0] data_in;
    logic       in_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic [4:0] count;
    logic       almost_full;
    logic [4:0] max_level;

    output_fifo #(.DATA_SIZE(8), .DEPTH(16), .AF_LEVEL(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .in_ready    (in_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .count       (count),
        .almost_full (almost_full),
        .max_level   (max_level)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         m_count = 0;
    int         m_max   = 0;

    logic       t_wr;
    logic       t_rd;
    logic [7:0] t_exp;
    logic [7:0] t_got;

    task automatic model_reset();
        exp_q.delete();
        m_count = 0;
        m_max   = 0;
    endtask

    // Drives one cycle at the falling edge, predicts the handshake from the
    // model, updates the scoreboard and returns 1 ns after the next rising edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic r,
                         output logic wr, output logic rd,
                         output logic [7:0] exp_rd, output logic [7:0] got_rd);
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        rd_ready = r;
        wr       = v && (m_count != 16);
        rd       = r && (m_count != 0);
        got_rd   = rd_data;
        exp_rd   = 8'h00;
        if (rd) exp_rd = exp_q.pop_front();
        if (wr) exp_q.push_back(d);
        m_count = m_count + (wr ? 1 : 0) - (rd ? 1 : 0);
        if (m_count > m_max) m_max = m_count;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'h5A;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        valid_in = 1'b0;
        model_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (max_level !== 5'd0) begin bad++; $display("FAIL reset_max_level got=%0d exp=0", max_level); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
        drive(1'b0, 8'h00, 1'b0, t_wr, t_rd, t_exp, t_got);
        total++; if (count !== 5'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL reset_no_store count=%0d rd_valid=%b exp=0/0", count, rd_valid); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, t_wr, t_rd, t_exp, t_got);
            total++; if (count !== 5'(i)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count, i); end
            total++; if (almost_full !== (i >= 12)) begin bad++; $display("FAIL fill_almost_full write=%0d got=%b exp=%b", i, almost_full, (i >= 12)); end
            total++; if (in_ready !== (i != 16)) begin bad++; $display("FAIL fill_in_ready write=%0d got=%b exp=%b", i, in_ready, (i != 16)); end
        end
        repeat (2) begin
            drive(1'b1, 8'h11, 1'b0, t_wr, t_rd, t_exp, t_got);
            total++; if (count !== 5'd16 || in_ready !== 1'b0) begin bad++; $display("FAIL fill_held_word count=%0d in_ready=%b exp=16/0", count, in_ready); end
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, t_wr, t_rd, t_exp, t_got);
            total++; if (t_got !== 8'(i + 1) || t_exp !== 8'(i + 1)) begin bad++; $display("FAIL drain_data got=%0h exp=%0h", t_got, i + 1); end
            total++; if (count !== 5'(15 - i)) begin bad++; $display("FAIL drain_count got=%0d exp=%0d", count, 15 - i); end
        end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL drain_rd_valid got=%b exp=0", rd_valid); end
        total++; if (max_level !== 5'd16) begin bad++; $display("FAIL drain_max_level got=%0d exp=16", max_level); end
        drive(1'b0, 8'h00, 1'b1, t_wr, t_rd, t_exp, t_got);
        total++; if (count !== 5'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL drain_empty_read count=%0d rd_valid=%b exp=0/0", count, rd_valid); end
    endtask

    task automatic test_simul_full();
        for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b0, t_wr, t_rd, t_exp, t_got);
        drive(1'b1, 8'h11, 1'b1, t_wr, t_rd, t_exp, t_got);
        total++; if (t_got !== 8'h01) begin bad++; $display("FAIL simul_read got=%0h exp=01", t_got); end
        total++; if (count !== 5'd15) begin bad++; $display("FAIL simul_no_write count=%0d exp=15", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL simul_in_ready got=%b exp=1", in_ready); end
        drive(1'b1, 8'h11, 1'b0, t_wr, t_rd, t_exp, t_got);
        total++; if (count !== 5'd16) begin bad++; $display("FAIL simul_refill count=%0d exp=16", count); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, t_wr, t_rd, t_exp, t_got);
            total++; if (t_got !== t_exp || t_exp !== 8'(i + 2)) begin bad++; $display("FAIL simul_order got=%0h exp=%0h", t_got, i + 2); end
        end
    endtask

    task automatic test_stream();
        int         sent = 0;
        int         cycles = 0;
        logic [7:0] next_word = 8'h40;
        logic       v;
        logic       r;
        while ((sent < 100 || exp_q.size() != 0) && cycles < 3000) begin
            v = (sent < 100) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            drive(v, next_word, r, t_wr, t_rd, t_exp, t_got);
            cycles++;
            if (t_wr) begin
                sent++;
                next_word = next_word + 8'd1;
            end
            if (t_rd) begin
                total++; if (t_got !== t_exp) begin bad++; $display("FAIL stream_data got=%0h exp=%0h", t_got, t_exp); end
            end
            total++; if (count !== 5'(m_count) || count > 5'd16) begin bad++; $display("FAIL stream_count got=%0d exp=%0d", count, m_count); end
            total++; if (max_level !== 5'(m_max)) begin bad++; $display("FAIL stream_max_level got=%0d exp=%0d", max_level, m_max); end
        end
        total++; if (cycles >= 3000) begin bad++; $display("FAIL stream_timeout sent=%0d pending=%0d exp=100/0", sent, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, t_wr, t_rd, t_exp, t_got);
        total++; if (count !== 5'd5) begin bad++; $display("FAIL mid_pre_count got=%0d exp=5", count); end
        @(negedge clk);
        reset    = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'h77;
        rd_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        total++; if (count !== 5'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL mid_reset count=%0d rd_valid=%b exp=0/0", count, rd_valid); end
        total++; if (max_level !== 5'd0) begin bad++; $display("FAIL mid_max_level got=%0d exp=0", max_level); end
        @(negedge clk);
        reset    = 1'b1;
        valid_in = 1'b0;
        drive(1'b1, 8'hAA, 1'b0, t_wr, t_rd, t_exp, t_got);
        total++; if (count !== 5'd1 || max_level !== 5'd1) begin bad++; $display("FAIL mid_after_write count=%0d max=%0d exp=1/1", count, max_level); end
        drive(1'b0, 8'h00, 1'b1, t_wr, t_rd, t_exp, t_got);
        total++; if (t_got !== 8'hAA || t_exp !== 8'hAA) begin bad++; $display("FAIL mid_first_read got=%0h exp=aa", t_got); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simul_full();
        test_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
